// File: rtl/alu_uart_sequencer_pkg.sv
// Shared types and constants for the ALU/UART frame controller.
// Holds the FSM state encoding and the opcode set understood by the ALU.
package alu_uart_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_uart_sequencer_frame_timer.sv
// Inter-byte watchdog: counts enabled cycles and flags the last allowed one.
// A zero TIMEOUT_CYCLES keeps the counter at zero and never expires.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NB_TIMER       = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic                LP_ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [NB_TIMER-1:0] LP_LAST    =
    (TIMEOUT_CYCLES > 0) ? NB_TIMER'(TIMEOUT_CYCLES - 1) : {NB_TIMER{1'b0}};

  logic [NB_TIMER-1:0] r_count;

  // Cycle counter, held at zero whenever the frame is not in progress.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= {NB_TIMER{1'b0}};
    end else if (i_clear || !i_enable || !LP_ENABLED) begin
      r_count <= {NB_TIMER{1'b0}};
    end else begin
      r_count <= r_count + NB_TIMER'(1);
    end
  end

  assign o_expired = LP_ENABLED && i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Frame controller: gathers A, B and opcode bytes from the UART receiver,
// strobes the ALU, and hands the captured result to the UART transmitter.
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OPERADOR    = 6,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NB_TIMER       = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rx_done,
  input  logic [NB_DATA-1:0]     i_rx_data,
  input  logic [NB_DATA-1:0]     i_resultado,
  input  logic                   i_tx_done,
  output logic [NB_DATA-1:0]     o_dato_a,
  output logic [NB_DATA-1:0]     o_dato_b,
  output logic [NB_OPERADOR-1:0] o_operador,
  output logic                   o_alu_valid,
  output logic                   o_tx_start,
  output logic [NB_DATA-1:0]     o_tx_data,
  output logic                   o_overrun,
  output logic                   o_timeout
);

  state_e                 r_state;
  logic [NB_DATA-1:0]     r_dato_a;
  logic [NB_DATA-1:0]     r_dato_b;
  logic [NB_OPERADOR-1:0] r_operador;
  logic                   r_alu_valid;
  logic                   r_tx_start;
  logic [NB_DATA-1:0]     r_tx_data;
  logic                   r_overrun;
  logic                   r_timeout;

  logic w_in_frame;
  logic w_busy;
  logic w_expired;

  assign w_in_frame = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_busy     = (r_state == ST_EXEC) || (r_state == ST_SEND) ||
                      (r_state == ST_WAIT_TX);

  // Any received byte restarts the inter-byte window.
  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NB_TIMER      (NB_TIMER)
  ) u_frame_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (i_rx_done),
    .i_enable (w_in_frame),
    .o_expired(w_expired)
  );

  // Frame FSM with registered ALU/transmitter handshakes and status flags.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_WAIT_A;
      r_dato_a    <= {NB_DATA{1'b0}};
      r_dato_b    <= {NB_DATA{1'b0}};
      r_operador  <= {NB_OPERADOR{1'b0}};
      r_alu_valid <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= {NB_DATA{1'b0}};
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_alu_valid <= 1'b0;
      r_tx_start  <= 1'b0;
      r_timeout   <= 1'b0;
      if (i_rx_done && w_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_WAIT_A: begin
          if (i_rx_done) begin
            r_dato_a <= i_rx_data;
            r_state  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done) begin
            r_dato_b <= i_rx_data;
            r_state  <= ST_WAIT_OP;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_done) begin
            r_operador  <= i_rx_data[NB_OPERADOR-1:0];
            r_alu_valid <= 1'b1;
            r_state     <= ST_EXEC;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= ST_WAIT_A;
          end
        end
        ST_EXEC: begin
          r_tx_data  <= i_resultado;
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            r_state <= ST_WAIT_A;
          end
        end
        default: begin
          r_state <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign o_dato_a    = r_dato_a;
  assign o_dato_b    = r_dato_b;
  assign o_operador  = r_operador;
  assign o_alu_valid = r_alu_valid;
  assign o_tx_start  = r_tx_start;
  assign o_tx_data   = r_tx_data;
  assign o_overrun   = r_overrun;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: a behavioural ALU, pulse-level UART stimulus,
// and a scoreboard monitor that checks every transmitted result byte.
module tb_alu_uart_sequencer;
  import alu_uart_sequencer_pkg::*;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rx_done = 1'b0;
  logic [NB_DATA-1:0] rx_data = 8'h00;
  logic               tx_done = 1'b0;
  logic [NB_DATA-1:0] resultado;
  logic [NB_DATA-1:0] o_dato_a, o_dato_b, o_tx_data;
  logic [NB_OP-1:0]   o_operador;
  logic               o_alu_valid, o_tx_start, o_overrun, o_timeout;

  logic [NB_DATA-1:0] sb_q[$];
  logic [NB_DATA-1:0] mon_exp;
  logic               prev_valid = 1'b0;
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 n_timeouts = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: shifts move operand A by operand B.
  always_comb begin
    resultado = 8'h00;
    case (o_operador)
      OP_ADD:  resultado = o_dato_a + o_dato_b;
      OP_SUB:  resultado = o_dato_a - o_dato_b;
      OP_AND:  resultado = o_dato_a & o_dato_b;
      OP_OR:   resultado = o_dato_a | o_dato_b;
      OP_XOR:  resultado = o_dato_a ^ o_dato_b;
      OP_NOR:  resultado = ~(o_dato_a | o_dato_b);
      OP_SRA:  resultado = 8'($signed(o_dato_a) >>> o_dato_b);
      OP_SRL:  resultado = o_dato_a >> o_dato_b;
      default: resultado = 8'h00;
    endcase
  end

  alu_uart_sequencer #(
    .NB_DATA(NB_DATA), .NB_OPERADOR(NB_OP), .TIMEOUT_CYCLES(TO), .NB_TIMER(16)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_resultado(resultado), .i_tx_done(tx_done),
    .o_dato_a(o_dato_a), .o_dato_b(o_dato_b), .o_operador(o_operador),
    .o_alu_valid(o_alu_valid), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every o_tx_start pops one expected byte from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_timeout) n_timeouts++;
        if (o_tx_start) begin
          check("alu_valid_before_start", 64'(prev_valid), 64'd1);
          check("tx_start_expected", 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            check("tx_data", 64'(o_tx_data), 64'(mon_exp));
          end
        end
        prev_valid = o_alu_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  function automatic logic [7:0] opb(input logic [5:0] op);
    return {2'b00, op};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_start();
    bit found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_tx_start) begin
        found = 1'b1;
        break;
      end
    end
    check("tx_start_seen", 64'(found), 64'd1);
  endtask

  task automatic pulse_tx();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] exp, input bit auto_tx);
    sb_q.push_back(exp);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("alu_valid_latency", 64'(o_alu_valid), 64'd1);
    wait_start();
    if (auto_tx) pulse_tx();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_dato_a, o_dato_b, o_operador, o_alu_valid, o_tx_start,
                o_tx_data, o_overrun, o_timeout});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(8'h05, 8'h03, opb(OP_ADD), 8'h08, 1'b1);
    frame(8'h03, 8'h05, opb(OP_SUB), 8'hFE, 1'b1);
    frame(8'hF0, 8'h02, opb(OP_SRA), 8'hFC, 1'b1);
    frame(8'hF0, 8'h02, opb(OP_SRL), 8'h3C, 1'b1);

    // Partial frame: only A, timeout expected 16 cycles later.
    send_byte(8'h77);
    begin
      int seen_at = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (o_timeout && seen_at == 0) seen_at = k;
      end
      check("timeout_cycle", 64'(seen_at), 64'd16);
    end
    check("timeout_count", 64'(n_timeouts), 64'd1);
    frame(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b1);

    // Byte B arrives on the last allowed cycle and must win over the timeout.
    sb_q.push_back(8'h08);
    send_byte(8'h0C);
    repeat (14) @(negedge clk);
    send_byte(8'h0A);
    send_byte(opb(OP_AND));
    wait_start();
    pulse_tx();
    check("no_timeout_on_expiry_byte", 64'(n_timeouts), 64'd1);

    check("overrun_clear", 64'(o_overrun), 64'd0);
    frame(8'h11, 8'h22, opb(OP_ADD), 8'h33, 1'b0);
    send_byte(8'hAA);
    check("overrun_set", 64'(o_overrun), 64'd1);
    pulse_tx();
    frame(8'h01, 8'h01, 8'h20, 8'h02, 1'b1);
    check("overrun_sticky", 64'(o_overrun), 64'd1);

    frame(8'h12, 8'h34, 8'h3F, 8'h00, 1'b1);
    frame(8'h10, 8'h20, 8'hE0, 8'h30, 1'b1);
    frame(8'h5A, 8'hFF, opb(OP_XOR), 8'hA5, 1'b1);
    frame(8'h0F, 8'hF0, opb(OP_NOR), 8'h00, 1'b1);
    frame(8'hFF, 8'h01, opb(OP_ADD), 8'h00, 1'b1);

    // Reset while waiting for the opcode.
    send_byte(8'h12);
    send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    check("reset_in_wait_op", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset while waiting for the transmitter.
    frame(8'h40, 8'h02, opb(OP_SRL), 8'h10, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_in_wait_tx", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    pulse_tx();
    frame(8'h09, 8'h06, opb(OP_OR), 8'h0F, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("final_timeout_count", 64'(n_timeouts), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
